// File: rtl/ag_stage_split_if.sv
// Upstream op / downstream beat bundle for ag_stage_split.
// slave is the stage itself; master is whatever drives ops in and takes beats out.
interface ag_stage_split_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned TAG_W = 64,
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             in_v;
    logic [AW-1:0]    in_base;
    logic [AW-1:0]    in_index;
    logic [1:0]       in_scale;
    logic [AW-1:0]    in_disp;
    logic [AW-1:0]    in_seg_base;
    logic [AW-1:0]    in_seg_limit;
    logic [1:0]       in_size;
    logic             in_chk;
    logic [TAG_W-1:0] in_tag;
    logic             in_stall;
    logic             down_stall;
    logic             out_v;
    logic [AW-1:0]    out_addr;
    logic             out_first;
    logic             out_last;
    logic             out_fault;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] split_cnt;

    modport master (
        output flush, in_v, in_base, in_index, in_scale, in_disp, in_seg_base,
               in_seg_limit, in_size, in_chk, in_tag, down_stall,
        input  in_stall, out_v, out_addr, out_first, out_last, out_fault, out_tag, split_cnt
    );

    modport slave (
        input  flush, in_v, in_base, in_index, in_scale, in_disp, in_seg_base,
               in_seg_limit, in_size, in_chk, in_tag, down_stall,
        output in_stall, out_v, out_addr, out_first, out_last, out_fault, out_tag, split_cnt
    );
endinterface

// File: rtl/ag_stage_split.sv
// Address-generation stage: effective offset, linear address, limit check, and a
// two-beat sequencer that splits accesses crossing a cache-line boundary.
module ag_stage_split #(
    parameter int unsigned AW        = 32,
    parameter int unsigned TAG_W     = 64,
    parameter int unsigned LINE_LOG2 = 4,
    parameter int unsigned CNT_W     = 16
) (
    input logic             CLK,
    input logic             CLR,
    ag_stage_split_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    // Wide enough to hold offset-in-line plus up to 8 bytes without overflow.
    localparam int unsigned SW = LINE_LOG2 + 5;

    state_e           state_q, state_d;
    logic             out_v_q, out_v_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             out_fault_q, out_fault_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [AW-1:0]    addr2_q, addr2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [AW-1:0]    off;
    logic [AW-1:0]    lin;
    logic [AW-1:0]    addr2;
    logic [AW:0]      last_byte;
    logic [SW-1:0]    line_end;
    logic             fault;
    logic             split;

    assign off       = bus.in_base + (bus.in_index << bus.in_scale) + bus.in_disp;
    assign lin       = bus.in_seg_base + off;
    // One extra bit so an access running past 2^AW still compares above the limit.
    assign last_byte = {1'b0, off} + ((AW+1)'(1) << bus.in_size) - (AW+1)'(1);
    assign fault     = bus.in_chk & (last_byte > {1'b0, bus.in_seg_limit});
    assign line_end  = SW'(lin[LINE_LOG2-1:0]) + (SW'(1) << bus.in_size);
    assign split     = ~fault & (line_end > (SW'(1) << LINE_LOG2));
    assign addr2     = {lin[AW-1:LINE_LOG2] + (AW-LINE_LOG2)'(1), {LINE_LOG2{1'b0}}};

    assign bus.in_stall = bus.in_v & ~bus.flush & (bus.down_stall | (state_q == StSecond));

    always_comb begin
        state_d     = state_q;
        out_v_d     = out_v_q;
        out_addr_d  = out_addr_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_fault_d = out_fault_q;
        out_tag_d   = out_tag_q;
        addr2_d     = addr2_q;
        cnt_d       = cnt_q;
        if (bus.flush) begin
            state_d = StIdle;
            out_v_d = 1'b0;
        end else if (!bus.down_stall) begin
            case (state_q)
                StIdle: begin
                    if (bus.in_v) begin
                        out_v_d     = 1'b1;
                        out_addr_d  = lin;
                        out_first_d = 1'b1;
                        out_last_d  = ~split;
                        out_fault_d = fault;
                        out_tag_d   = bus.in_tag;
                        if (split) begin
                            state_d = StSecond;
                            addr2_d = addr2;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        out_v_d = 1'b0;
                    end
                end
                StSecond: begin
                    // Tag register already holds the op's payload from beat 1.
                    out_v_d     = 1'b1;
                    out_addr_d  = addr2_q;
                    out_first_d = 1'b0;
                    out_last_d  = 1'b1;
                    out_fault_d = 1'b0;
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= StIdle;
            out_v_q     <= 1'b0;
            out_addr_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_fault_q <= 1'b0;
            out_tag_q   <= '0;
            addr2_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_v_q     <= out_v_d;
            out_addr_q  <= out_addr_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_fault_q <= out_fault_d;
            out_tag_q   <= out_tag_d;
            addr2_q     <= addr2_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_v     = out_v_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_fault = out_fault_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.split_cnt = cnt_q;
endmodule

// File: tb/tb_ag_stage_split.sv
// Scoreboard bench for ag_stage_split: directed cases from the plan plus randomized ops
// with random down_stall / flush, checked against a plain-arithmetic reference model.
module tb_ag_stage_split;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned CNT_MAX    = 15;

    typedef struct {
        logic [31:0] addr;
        logic        first;
        logic        last;
        logic        fault;
        logic [63:0] tag;
    } beat_t;

    logic CLK = 1'b0;
    logic CLR = 1'b1;

    ag_stage_split_if #(.AW(32), .TAG_W(64), .CNT_W(4)) bus ();

    ag_stage_split #(.AW(32), .TAG_W(64), .LINE_LOG2(4), .CNT_W(4)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned model_cnt = 0;
    bit          second = 1'b0;
    bit          armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: whole op computed from the arithmetic rules, beats queued in order.
    task automatic model_accept();
        longint unsigned m = 64'h1_0000_0000;
        longint unsigned off, lin, bytes;
        bit f, s;
        beat_t b;
        off   = (longint'(bus.in_base) + longint'(bus.in_index) * (64'd1 << bus.in_scale)
                 + longint'(bus.in_disp)) % m;
        lin   = (longint'(bus.in_seg_base) + off) % m;
        bytes = 64'd1 << bus.in_size;
        f     = bus.in_chk && (off + bytes - 1 > longint'(bus.in_seg_limit));
        s     = !f && ((lin % LINE_BYTES) + bytes > LINE_BYTES);
        b.addr = lin[31:0]; b.first = 1'b1; b.last = !s; b.fault = f; b.tag = bus.in_tag;
        exp_q.push_back(b);
        if (s) begin
            lin = ((lin / LINE_BYTES + 1) * LINE_BYTES) % m;
            b.addr = lin[31:0]; b.first = 1'b0; b.last = 1'b1; b.fault = 1'b0;
            exp_q.push_back(b);
            second = 1'b1;
            if (model_cnt < CNT_MAX) model_cnt++;
        end
    endtask

    task automatic tick(output bit acc);
        acc = 1'b0;
        @(posedge CLK);
        if (CLR) begin
            exp_q.delete();
            second = 1'b0;
            model_cnt = 0;
        end else if (bus.flush) begin
            exp_q.delete();
            second = 1'b0;
        end else if (!bus.down_stall) begin
            if (second) second = 1'b0;
            else if (bus.in_v) begin
                acc = 1'b1;
                model_accept();
            end
        end
        #1;
    endtask

    task automatic set_op(input logic [31:0] base, input logic [31:0] index,
                          input logic [1:0] scale, input logic [31:0] disp,
                          input logic [31:0] segb, input logic [31:0] lim,
                          input logic [1:0] size, input logic chk);
        bus.in_base = base; bus.in_index = index; bus.in_scale = scale; bus.in_disp = disp;
        bus.in_seg_base = segb; bus.in_seg_limit = lim; bus.in_size = size; bus.in_chk = chk;
        bus.in_tag = {$urandom(), $urandom()};
    endtask

    task automatic issue(input int stall_pct, input int flush_pct);
        bit acc;
        bit fl;
        int n = 0;
        bus.in_v = 1'b1;
        do begin
            bus.down_stall = ($urandom_range(0, 99) < stall_pct);
            bus.flush = ($urandom_range(0, 99) < flush_pct);
            fl = bus.flush;
            tick(acc);
            n++;
        end while (!acc && !fl && n < 64);
        if (!acc && !fl) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op not accepted after %0d cycles", n);
        end
        bus.in_v = 1'b0; bus.flush = 1'b0; bus.down_stall = 1'b0;
    endtask

    task automatic idle(input int n, input int stall_pct);
        bit acc;
        bus.in_v = 1'b0; bus.flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.down_stall = ($urandom_range(0, 99) < stall_pct);
            tick(acc);
        end
        bus.down_stall = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_v"}, bus.out_v, 0);
        check({tag, "_first"}, bus.out_first, 0);
        check({tag, "_last"}, bus.out_last, 0);
        check({tag, "_fault"}, bus.out_fault, 0);
        check({tag, "_addr"}, bus.out_addr, 0);
        check({tag, "_tag"}, bus.out_tag, 0);
        check({tag, "_cnt"}, bus.split_cnt, 0);
    endtask

    // Monitor: compares the presented beat every cycle, retires it once downstream takes it.
    always @(negedge CLK) begin
        if (armed && !CLR) begin
            check("in_stall", bus.in_stall, bus.in_v & ~bus.flush & (bus.down_stall | second));
            check("out_v", bus.out_v, exp_q.size() != 0);
            check("split_cnt", bus.split_cnt, model_cnt);
            if (bus.out_v && exp_q.size() != 0) begin
                check("beat_addr", bus.out_addr, exp_q[0].addr);
                check("beat_first", bus.out_first, exp_q[0].first);
                check("beat_last", bus.out_last, exp_q[0].last);
                check("beat_fault", bus.out_fault, exp_q[0].fault);
                check("beat_tag", bus.out_tag, exp_q[0].tag);
                if (!bus.down_stall) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit acc;
        bus.flush = 1'b0; bus.in_v = 1'b0; bus.down_stall = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        tick(acc);
        tick(acc);
        CLR = 1'b0;
        check_zero("reset");
        armed = 1'b1;

        // Aligned load
        set_op(32'h20, 32'h2, 2'd2, 32'h4, 32'h1000, 32'hFFFF_FFFF, 2'd2, 1'b0);
        issue(0, 0);
        check("aligned_addr", bus.out_addr, 32'h102C);
        check("aligned_last", bus.out_last, 1);
        idle(2, 0);

        // Line cross: beat 1, stall seen in SECOND, then beat 2
        set_op(0, 0, 0, 32'hE, 32'h1000, 32'hFFFF_FFFF, 2'd2, 1'b0);
        issue(0, 0);
        check("cross_b1_addr", bus.out_addr, 32'h100E);
        check("cross_b1_last", bus.out_last, 0);
        bus.in_v = 1'b1;
        #1 check("cross_in_stall", bus.in_stall, 1);
        bus.in_v = 1'b0;
        tick(acc);
        check("cross_b2_addr", bus.out_addr, 32'h1010);
        check("cross_b2_first", bus.out_first, 0);
        check("cross_cnt", bus.split_cnt, 1);
        idle(2, 0);

        // Limit fault on a line-crossing access stays single beat
        set_op(0, 0, 0, 32'hFFE, 32'h1000, 32'hFFF, 2'd2, 1'b1);
        issue(0, 0);
        check("fault_flag", bus.out_fault, 1);
        check("fault_last", bus.out_last, 1);
        idle(2, 0);

        // Ends exactly on a line boundary
        set_op(0, 0, 0, 32'hC, 32'h1000, 32'hFFFF_FFFF, 2'd2, 1'b0);
        issue(0, 0);
        check("boundary_last", bus.out_last, 1);
        idle(2, 0);

        // Address wrap on beat 2
        set_op(0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 2'd3, 1'b0);
        issue(0, 0);
        tick(acc);
        check("wrap_b2_addr", bus.out_addr, 32'h0);
        idle(2, 0);

        // down_stall for 3 cycles while in SECOND
        set_op(32'h3FF, 0, 0, 32'h0, 32'h2000, 32'hFFFF_FFFF, 2'd1, 1'b0);
        issue(0, 0);
        idle(3, 100);
        idle(3, 0);

        // Flush in SECOND drops beat 2
        set_op(0, 0, 0, 32'hF, 32'h1000, 32'hFFFF_FFFF, 2'd3, 1'b0);
        issue(0, 0);
        bus.flush = 1'b1;
        tick(acc);
        bus.flush = 1'b0;
        check("flush_out_v", bus.out_v, 0);
        idle(2, 0);

        // Reset in SECOND
        set_op(0, 0, 0, 32'hF, 32'h1000, 32'hFFFF_FFFF, 2'd3, 1'b0);
        issue(0, 0);
        CLR = 1'b1;
        tick(acc);
        check_zero("midreset");
        CLR = 1'b0;
        idle(1, 0);

        // Counter saturation (4-bit counter in this bench)
        for (int i = 0; i < 20; i++) begin
            set_op(0, 0, 0, 32'hE, 32'h1000, 32'hFFFF_FFFF, 2'd2, 1'b0);
            issue(0, 0);
            idle(1, 0);
        end
        check("sat_cnt", bus.split_cnt, 15);

        // Randomized ops under random back-pressure and flush
        for (int n = 0; n < 300; n++) begin
            set_op($urandom(), $urandom(), 2'($urandom_range(0, 3)), $urandom(), $urandom(),
                   ($urandom_range(0, 1) != 0) ? $urandom() : 32'hFFFF_FFFF,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            issue(25, 5);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 25);
        end
        idle(6, 0);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
